histogram_engine: RTL and testbench

HISTOGRAM_ENGINE -- requirements
Module: histogram_engine

---
 rtl/histogram_engine.sv | 94 +++++++++
 tb/tb_histogram_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_engine.sv
// histogram_engine: streaming bin counter with 2-stage RMW pipeline and clear sweep; define HIST_SATURATE_EN for saturating counters
module histogram_engine #(
  parameter int NUM_BINS = 256,
  parameter int DATA_WIDTH = 16,
  parameter int COUNT_W = 32,
  localparam int AW = $clog2(NUM_BINS)
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  clear_in,
  input  logic [AW-1:0]         rd_addr_in,
  input  logic                  rd_req_in,
  output logic [COUNT_W-1:0]    rd_data_out,
  output logic                  rd_valid_out,
  output logic [COUNT_W-1:0]    total_out,
  output logic [COUNT_W-1:0]    dropped_out,
  output logic                  busy_out
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] idx, s1_a, s2_a;
  logic [COUNT_W-1:0] mem [NUM_BINS];
  logic [COUNT_W-1:0] s1_cnt, s2_cnt;
  logic s1_v, s2_v, accept, in_range, clr, rd_ok;

  function automatic logic [COUNT_W-1:0] inc(input logic [COUNT_W-1:0] x);
`ifdef HIST_SATURATE_EN
    return &x ? x : x + 1'b1;
`else
    return x + 1'b1;
`endif
  endfunction

  assign accept = valid_in && ready_out;
  assign in_range = (data_in >> AW) == '0;
  assign clr = state == RUN && clear_in;
  assign rd_ok = rd_req_in && state == RUN;
  assign s1_cnt = inc((s2_v && s2_a == s1_a) ? s2_cnt : mem[s1_a]);

  // state register
  always_ff @(posedge clk or posedge rst_in)
    if (rst_in) state <= CLEAR;
    else state <= state_nx;

  // next state: leave CLEAR after the last bin is zeroed, enter it on clear request
  always_comb
    state_nx = state == RUN ? (clear_in ? CLEAR : RUN) : (idx == AW'(NUM_BINS - 1) ? RUN : CLEAR);

  // FSM outputs
  always_comb begin
    ready_out = state == RUN && !clear_in;
    busy_out = state == CLEAR;
  end

  // sweep index, RMW pipeline registers and statistics counters
  always_ff @(posedge clk or posedge rst_in)
    if (rst_in) begin
      idx <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_a <= '0;
      s2_a <= '0;
      s2_cnt <= '0;
      total_out <= '0;
      dropped_out <= '0;
    end else begin
      idx <= state == CLEAR ? idx + 1'b1 : '0;
      s1_v <= accept && in_range;
      s1_a <= data_in[AW-1:0];
      s2_v <= s1_v && !clr;
      s2_a <= s1_a;
      s2_cnt <= s1_cnt;
      total_out <= clr ? '0 : (accept && in_range) ? inc(total_out) : total_out;
      dropped_out <= clr ? '0 : (accept && !in_range) ? inc(dropped_out) : dropped_out;
    end

  // single write port: sweep zeroing in CLEAR, S2 write-back in RUN
  always_ff @(posedge clk)
    if (state == CLEAR) mem[idx] <= '0;
    else if (s2_v) mem[s2_a] <= s2_cnt;

  // readout forwards the pending S2 write so updates two cycles old are visible
  always_ff @(posedge clk or posedge rst_in)
    if (rst_in) begin
      rd_valid_out <= 1'b0;
      rd_data_out <= '0;
    end else begin
      rd_valid_out <= rd_ok;
      if (rd_ok) rd_data_out <= (s2_v && s2_a == rd_addr_in) ? s2_cnt : mem[rd_addr_in];
    end
endmodule

// File: tb/tb_histogram_engine.sv
// tb_histogram_engine: randomized and directed checks of histogram_engine against a bin-array model
module tb_histogram_engine;
  localparam int NB = 256, DW = 16, CW = 32, AW = 8;
  localparam int SNB = 16, SDW = 8, SCW = 4, SAW = 4;
  logic clk = 1'b0;
  logic rst_in;
  logic [DW-1:0] data_in;
  logic valid_in, clear_in, rd_req_in;
  logic [AW-1:0] rd_addr_in;
  logic ready_out, rd_valid_out, busy_out;
  logic [CW-1:0] rd_data_out, total_out, dropped_out;
  logic [SDW-1:0] s_data;
  logic s_valid, s_clear, s_rd_req;
  logic [SAW-1:0] s_rd_addr;
  logic s_ready, s_rd_valid, s_busy;
  logic [SCW-1:0] s_rd_data, s_total, s_dropped;
  int checks = 0, errors = 0;
  int mdl[NB];
  int m_total, m_dropped;
  logic rd_ok[NB];
  logic [CW-1:0] rd_got[NB];

  always #5 clk = ~clk;

  histogram_engine #(.NUM_BINS(NB), .DATA_WIDTH(DW), .COUNT_W(CW)) dut (
    .clk(clk), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .clear_in(clear_in), .rd_addr_in(rd_addr_in), .rd_req_in(rd_req_in), .rd_data_out(rd_data_out),
    .rd_valid_out(rd_valid_out), .total_out(total_out), .dropped_out(dropped_out), .busy_out(busy_out));

  histogram_engine #(.NUM_BINS(SNB), .DATA_WIDTH(SDW), .COUNT_W(SCW)) dut_s (
    .clk(clk), .rst_in(rst_in), .data_in(s_data), .valid_in(s_valid), .ready_out(s_ready),
    .clear_in(s_clear), .rd_addr_in(s_rd_addr), .rd_req_in(s_rd_req), .rd_data_out(s_rd_data),
    .rd_valid_out(s_rd_valid), .total_out(s_total), .dropped_out(s_dropped), .busy_out(s_busy));

  task automatic idle();
    data_in = '0; valid_in = 0; clear_in = 0; rd_req_in = 0; rd_addr_in = '0;
  endtask

  task automatic clear_model();
    foreach (mdl[i]) mdl[i] = 0;
    m_total = 0; m_dropped = 0;
  endtask

  task automatic do_sample(input int d);
    valid_in = 1; data_in = DW'(d);
    if (d < NB) begin mdl[d]++; m_total++; end
    else m_dropped++;
    @(negedge clk);
    valid_in = 0;
  endtask

  task automatic read_bin(input int a, output logic v, output logic [CW-1:0] d);
    rd_req_in = 1; rd_addr_in = AW'(a);
    @(negedge clk);
    rd_req_in = 0; v = rd_valid_out; d = rd_data_out;
  endtask

  task automatic read_all();
    for (int i = 0; i < NB; i++) begin
      rd_req_in = 1; rd_addr_in = AW'(i);
      @(negedge clk);
      rd_ok[i] = rd_valid_out; rd_got[i] = rd_data_out;
    end
    rd_req_in = 0;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy_out && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_in = 1;
    #1;
    checks++;
    if (ready_out !== 0 || busy_out !== 1 || total_out !== 0 || dropped_out !== 0 || rd_valid_out !== 0 || rd_data_out !== 0) begin
      errors++; $display("FAIL reset_outputs ready=%0b busy=%0b total=%0d dropped=%0d rd_valid=%0b rd_data=%0d", ready_out, busy_out, total_out, dropped_out, rd_valid_out, rd_data_out);
    end
    repeat (3) @(negedge clk);
    rst_in = 0;
    clear_model();
    wait_sweep(n);
    checks++;
    if (n !== 256 || ready_out !== 1) begin
      errors++; $display("FAIL reset_sweep busy_cycles=%0d ready=%0b expected 256 and 1", n, ready_out);
    end
    read_all();
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (rd_ok[i] !== 1 || rd_got[i] !== CW'(mdl[i])) begin
        errors++; $display("FAIL reset_bin%0d valid=%0b got %0d expected %0d", i, rd_ok[i], rd_got[i], mdl[i]);
      end
    end
  endtask

  task automatic test_forwarding();
    logic v;
    logic [CW-1:0] d;
    for (int i = 0; i < 10; i++) do_sample(7);
    @(negedge clk);
    read_bin(7, v, d);
    checks++;
    if (v !== 1 || d !== CW'(mdl[7]) || d !== 10) begin
      errors++; $display("FAIL fwd_bin7 valid=%0b got %0d expected 10", v, d);
    end
    checks++;
    if (total_out !== CW'(m_total) || total_out !== 10) begin
      errors++; $display("FAIL fwd_total got %0d expected 10", total_out);
    end
    @(negedge clk);
    checks++;
    if (rd_valid_out !== 0 || rd_data_out !== 10) begin
      errors++; $display("FAIL rd_hold valid=%0b data=%0d expected 0 and 10", rd_valid_out, rd_data_out);
    end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 5; i++) do_sample($urandom_range(0, 15));
    valid_in = 1; data_in = 16'd5; clear_in = 1;
    #1;
    checks++;
    if (ready_out !== 0) begin
      errors++; $display("FAIL clear_ready got %0b expected 0", ready_out);
    end
    @(negedge clk);
    idle();
    clear_model();
    checks++;
    if (total_out !== 0 || dropped_out !== 0 || busy_out !== 1) begin
      errors++; $display("FAIL clear_stats total=%0d dropped=%0d busy=%0b expected 0 0 1", total_out, dropped_out, busy_out);
    end
    n = 0;
    while (busy_out && n < 1000) begin
      clear_in = (n == 100); rd_req_in = (n == 50); rd_addr_in = 8'd3;
      @(negedge clk);
      if (n == 50) begin
        checks++;
        if (rd_valid_out !== 0) begin
          errors++; $display("FAIL clear_read_ignored rd_valid=%0b expected 0", rd_valid_out);
        end
      end
      n++;
    end
    idle();
    checks++;
    if (n !== 256 || ready_out !== 1) begin
      errors++; $display("FAIL clear_sweep busy_cycles=%0d ready=%0b expected 256 and 1", n, ready_out);
    end
    read_all();
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (rd_ok[i] !== 1 || rd_got[i] !== CW'(mdl[i])) begin
        errors++; $display("FAIL clear_bin%0d valid=%0b got %0d expected %0d", i, rd_ok[i], rd_got[i], mdl[i]);
      end
    end
  endtask

  task automatic test_range();
    logic v;
    logic [CW-1:0] d;
    do_sample(300); do_sample(255); do_sample(0);
    repeat (2) @(negedge clk);
    checks++;
    if (dropped_out !== 1 || total_out !== 2 || dropped_out !== CW'(m_dropped)) begin
      errors++; $display("FAIL range_counts dropped=%0d total=%0d expected 1 and 2", dropped_out, total_out);
    end
    read_bin(255, v, d);
    checks++;
    if (v !== 1 || d !== 1) begin
      errors++; $display("FAIL range_bin255 valid=%0b got %0d expected 1", v, d);
    end
    read_bin(0, v, d);
    checks++;
    if (v !== 1 || d !== CW'(mdl[0])) begin
      errors++; $display("FAIL range_bin0 valid=%0b got %0d expected %0d", v, d, mdl[0]);
    end
  endtask

  task automatic test_random_stream();
    logic pv, pend_v, rq, sv;
    int pexp, pend_a, a, d;
    pv = 0; pend_v = 0; pexp = 0; pend_a = 0;
    @(negedge clk);
    for (int it = 0; it < 600; it++) begin
      checks++;
      if (rd_valid_out !== pv || (pv && rd_data_out !== CW'(pexp))) begin
        errors++; $display("FAIL stream_read it=%0d valid=%0b data=%0d expected valid=%0b data=%0d", it, rd_valid_out, rd_data_out, pv, pexp);
      end
      checks++;
      if (total_out !== CW'(m_total) || dropped_out !== CW'(m_dropped)) begin
        errors++; $display("FAIL stream_counts it=%0d total=%0d dropped=%0d expected %0d %0d", it, total_out, dropped_out, m_total, m_dropped);
      end
      a = $urandom_range(0, 15);
      rq = ($urandom_range(0, 1) == 1) && !(pend_v && pend_a == a);
      pv = rq; pexp = mdl[a];
      if (pend_v) mdl[pend_a]++;
      sv = $urandom_range(0, 3) != 0;
      d = ($urandom_range(0, 7) == 0) ? NB + $urandom_range(0, 3) : $urandom_range(0, 15);
      pend_v = sv && d < NB; pend_a = d;
      if (sv) begin
        if (d < NB) m_total++;
        else m_dropped++;
      end
      valid_in = sv; data_in = DW'(d); rd_req_in = rq; rd_addr_in = AW'(a);
      @(negedge clk);
    end
    idle();
    if (pend_v) mdl[pend_a]++;
    repeat (2) @(negedge clk);
    read_all();
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (rd_ok[i] !== 1 || rd_got[i] !== CW'(mdl[i])) begin
        errors++; $display("FAIL stream_bin%0d valid=%0b got %0d expected %0d", i, rd_ok[i], rd_got[i], mdl[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic v;
    logic [CW-1:0] d;
    int n;
    for (int i = 0; i < 3; i++) do_sample(2);
    @(negedge clk);
    read_bin(2, v, d);
    checks++;
    if (v !== 1 || d !== CW'(mdl[2])) begin
      errors++; $display("FAIL arst_preread valid=%0b got %0d expected %0d", v, d, mdl[2]);
    end
    valid_in = 1; data_in = 16'd4;
    #2 rst_in = 1;
    #1;
    checks++;
    if (total_out !== 0 || dropped_out !== 0 || rd_data_out !== 0 || rd_valid_out !== 0 || ready_out !== 0 || busy_out !== 1) begin
      errors++; $display("FAIL arst_outputs total=%0d dropped=%0d rd_data=%0d rd_valid=%0b ready=%0b busy=%0b", total_out, dropped_out, rd_data_out, rd_valid_out, ready_out, busy_out);
    end
    @(negedge clk);
    idle();
    rst_in = 0;
    clear_model();
    wait_sweep(n);
    checks++;
    if (n !== 256 || ready_out !== 1) begin
      errors++; $display("FAIL arst_sweep busy_cycles=%0d ready=%0b expected 256 and 1", n, ready_out);
    end
    read_all();
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (rd_ok[i] !== 1 || rd_got[i] !== CW'(mdl[i])) begin
        errors++; $display("FAIL arst_bin%0d valid=%0b got %0d expected %0d", i, rd_ok[i], rd_got[i], mdl[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int e;
    e = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1; s_data = 8'd3;
`ifdef HIST_SATURATE_EN
      e = (e == 15) ? 15 : e + 1;
`else
      e = (e + 1) % 16;
`endif
      @(negedge clk);
    end
    s_valid = 0;
    @(negedge clk);
    s_rd_req = 1; s_rd_addr = 4'd3;
    @(negedge clk);
    s_rd_req = 0;
    checks++;
    if (s_rd_valid !== 1 || s_rd_data !== SCW'(e)) begin
      errors++; $display("FAIL sat_bin3 valid=%0b got %0d expected %0d", s_rd_valid, s_rd_data, e);
    end
    checks++;
    if (s_total !== SCW'(e) || s_dropped !== 0) begin
      errors++; $display("FAIL sat_total got %0d dropped %0d expected %0d 0", s_total, s_dropped, e);
    end
  endtask

  initial begin
    idle();
    s_data = '0; s_valid = 0; s_clear = 0; s_rd_req = 0; s_rd_addr = '0;
    clear_model();
    test_reset();
    test_forwarding();
    test_clear();
    test_range();
    test_random_stream();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
